// File: rtl/sum_nb_seq.sv
// rtl/sum_nb_seq.sv - multi-cycle N-bit adder/subtractor, CHUNK bits per clock, LSB first
module sum_nb_seq #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic             sub,
    input  logic [WIDTH-1:0] xi,
    input  logic [WIDTH-1:0] yi,
    input  logic             ci,
    output logic [WIDTH-1:0] zi,
    output logic             co,
    output logic             ovf,
    output logic             zero,
    output logic             busy,
    output logic             done
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = $clog2(NCH) + 1;

    generate
        if ((WIDTH < 2) || (CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_param_err
            $error("sum_nb_seq: WIDTH must be >= 2 and a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, zi_q, zi_d;
    logic             a_msb_q, a_msb_d, b_msb_q, b_msb_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    count_q, count_d;
    logic             co_q, co_d, ovf_q, ovf_d, zero_q, zero_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic [CHUNK:0]   chunk_sum;

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        a_msb_d   = a_msb_q;
        b_msb_d   = b_msb_q;
        carry_d   = carry_q;
        zi_d      = zi_q;
        count_d   = count_q;
        co_d      = co_q;
        ovf_d     = ovf_q;
        zero_d    = zero_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        // a_q/b_q shift right each RUN cycle so the active chunk is always at the bottom
        chunk_sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]}
                  + {{CHUNK{1'b0}}, carry_q};
        case (state_q)
            IDLE: begin
                if (init) begin
                    a_d     = xi;
                    b_d     = sub ? ~yi : yi;
                    a_msb_d = xi[WIDTH-1];
                    b_msb_d = sub ? ~yi[WIDTH-1] : yi[WIDTH-1];
                    carry_d = sub | ci;
                    zi_d    = '0;
                    count_d = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                carry_d = chunk_sum[CHUNK];
                for (int i = 0; i < NCH; i++) begin
                    if (count_q == CW'(i)) begin
                        zi_d[i*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
                    end
                end
                count_d = count_q + CW'(1);
                if (count_q == CW'(NCH - 1)) begin
                    co_d    = chunk_sum[CHUNK];
                    ovf_d   = (a_msb_q == b_msb_q) && (zi_d[WIDTH-1] != a_msb_q);
                    zero_d  = (zi_d == '0);
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            carry_q <= 1'b0;
            zi_q    <= '0;
            count_q <= '0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            carry_q <= carry_d;
            zi_q    <= zi_d;
            count_q <= count_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign zi   = zi_q;
    assign co   = co_q;
    assign ovf  = ovf_q;
    assign zero = zero_q;
    assign busy = busy_q;
    assign done = done_q;
endmodule

// File: tb/tb_sum_nb_seq.sv
// tb/tb_sum_nb_seq.sv - randomized bench for sum_nb_seq, four CHUNK variants at WIDTH=8
module tb_sum_nb_seq;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] init_v = '0;
    logic       sub = 1'b0;
    logic       ci = 1'b0;
    logic [7:0] xi = '0;
    logic [7:0] yi = '0;
    logic [7:0] zi_w [4];
    logic [3:0] co_w, ovf_w, zero_w, busy_w, done_w;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_zi [4];
    logic [3:0] exp_co, exp_ovf, exp_zero;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        sum_nb_seq #(.WIDTH(8), .CHUNK(1 << g)) u_dut (
            .clk(clk), .rst(rst), .init(init_v[g]), .sub(sub),
            .xi(xi), .yi(yi), .ci(ci),
            .zi(zi_w[g]), .co(co_w[g]), .ovf(ovf_w[g]), .zero(zero_w[g]),
            .busy(busy_w[g]), .done(done_w[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values
    function automatic logic [10:0] model(input logic [7:0] x, input logic [7:0] y,
                                          input logic c, input logic s);
        int u, sr;
        logic [7:0] r;
        logic cout, v;
        if (s) begin
            u    = int'(x) - int'(y);
            sr   = int'($signed(x)) - int'($signed(y));
            cout = (x >= y);
        end else begin
            u    = int'(x) + int'(y) + int'(c);
            sr   = int'($signed(x)) + int'($signed(y)) + int'(c);
            cout = (u >= 256);
        end
        r = u[7:0];
        v = (sr > 127) || (sr < -128);
        return {(r == 8'h00), v, cout, r};
    endfunction

    // Starts an op on instance k; optional stray init with new operands at run cycle glitch_at
    task automatic run_op(input int k, input logic [7:0] x, input logic [7:0] y,
                          input logic c, input logic s, input int glitch_at);
        logic [10:0] e;
        int cyc;
        int nch;
        nch = 8 >> k;
        e = model(x, y, c, s);
        xi = x; yi = y; ci = c; sub = s;
        init_v[k] = 1'b1;
        @(posedge clk); #1;
        init_v[k] = 1'b0;
        xi = 8'($urandom); yi = 8'($urandom); ci = 1'($urandom); sub = 1'($urandom);
        check($sformatf("busy_start k%0d", k), busy_w[k], 1);
        check($sformatf("co_hold k%0d", k), co_w[k], exp_co[k]);
        cyc = 0;
        while (1) begin
            @(posedge clk); #1;
            cyc++;
            init_v[k] = (cyc == glitch_at);
            if (done_w[k] || cyc > 20) break;
        end
        init_v[k] = 1'b0;
        check($sformatf("latency k%0d", k), cyc, nch);
        check($sformatf("zi k%0d x%0h y%0h s%0d", k, x, y, s), zi_w[k], e[7:0]);
        check($sformatf("co k%0d", k), co_w[k], e[8]);
        check($sformatf("ovf k%0d", k), ovf_w[k], e[9]);
        check($sformatf("zero k%0d", k), zero_w[k], e[10]);
        check($sformatf("busy_end k%0d", k), busy_w[k], 0);
        exp_zi[k] = e[7:0]; exp_co[k] = e[8]; exp_ovf[k] = e[9]; exp_zero[k] = e[10];
        @(posedge clk); #1;
        check($sformatf("done_pulse k%0d", k), done_w[k], 0);
        check($sformatf("zi_held k%0d", k), zi_w[k], exp_zi[k]);
    endtask

    initial begin
        int k;
        exp_co = '0; exp_ovf = '0; exp_zero = '0;
        for (int i = 0; i < 4; i++) exp_zi[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rst_outs k%0d", i),
                  {zi_w[i], co_w[i], ovf_w[i], zero_w[i], busy_w[i], done_w[i]}, 0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(0, 8'h7F, 8'h01, 1'b0, 1'b0, 0);
        run_op(2, 8'hFF, 8'h01, 1'b0, 1'b0, 0);
        run_op(1, 8'h05, 8'h07, 1'b0, 1'b1, 0);
        run_op(1, 8'h80, 8'h01, 1'b0, 1'b1, 0);
        run_op(3, 8'h00, 8'h00, 1'b0, 1'b0, 0);
        run_op(0, 8'hFF, 8'hFF, 1'b1, 1'b0, 0);

        // stray init mid-run is ignored
        run_op(0, 8'h3C, 8'h5A, 1'b1, 1'b0, 3);

        for (int n = 0; n < 24; n++) begin
            k = $urandom_range(0, 3);
            run_op(k, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 0);
        end

        // reset during RUN cycle 4
        xi = 8'hA5; yi = 8'h3C; ci = 1'b0; sub = 1'b0;
        init_v[0] = 1'b1;
        @(posedge clk); #1;
        init_v[0] = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rst_mid_outs",
              {zi_w[0], co_w[0], ovf_w[0], zero_w[0], busy_w[0], done_w[0]}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_co = '0; exp_ovf = '0; exp_zero = '0;
        k = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (done_w[0]) k++;
        end
        check("rst_no_done", k, 0);
        run_op(0, 8'h12, 8'h34, 1'b1, 1'b0, 0);

        // init held high on CHUNK=8: back-to-back ops every 2 cycles
        xi = 8'h10; yi = 8'h20; ci = 1'b1; sub = 1'b0;
        init_v[3] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check($sformatf("b2b_busy %0d", i), busy_w[3], (i % 2 == 0));
            check($sformatf("b2b_done %0d", i), done_w[3], (i % 2 == 1));
            if (i % 2 == 1) check($sformatf("b2b_zi %0d", i), zi_w[3], 8'h31);
        end
        init_v[3] = 1'b0;
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
